ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Shares the single-port data/instruction RAM between two requesters: the instruction-fetch (IF) path and the load/store (LS) path, which drives the load address/data of the I-type unit and the store path.
- Registers each accepted request, sequences the RAM access (chip-enable, write, read latency), and returns read data or write completion with a one-cycle valid pulse.
- Sits between the core pipeline and the RAM; the load-extract logic (byte/half select, sign extension) stays in the instruction units.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 because BE is fixed at 4 bits.
- RAM_LAT, 1, RAM read latency in cycles, legal range 1..4.
- LS_PRIO, 0: 0 = round-robin on simultaneous requests; 1 = LS always wins.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  synchronous, active-high reset.
- iIF_REQ  in  1  fetch request; held until oIF_GNT.
- iIF_ADDR  in  ADDR_W  fetch address.
- oIF_GNT  out  1  fetch request accepted (1-cycle pulse).
- oIF_VALID  out  1  fetch data valid (1-cycle pulse).
- oIF_DATA  out  DATA_W  fetched word.
- iLS_REQ  in  1  load/store request; held until oLS_GNT.
- iLS_WR  in  1  1 = store, 0 = load.
- iLS_ADDR  in  ADDR_W  load/store address.
- iLS_WDATA  in  DATA_W  store data.
- iLS_BE  in  4  store byte enables.
- oLS_GNT  out  1  LS request accepted.
- oLS_VALID  out  1  load data valid / store complete.
- oLS_RDATA  out  DATA_W  raw loaded word.
- oRAM_CE  out  1  RAM chip enable.
- oRAM_WR  out  1  RAM write.
- oRAM_ADDR  out  ADDR_W  RAM address.
- oRAM_WDATA  out  DATA_W  RAM write data.
- oRAM_BE  out  4  RAM byte enables.
- iRAM_DATA  in  DATA_W  RAM read data.
- oBUSY  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- Reset values: all outputs 0; state IDLE; latency counter 0; round-robin pointer favours LS.
- IDLE:
  - If any REQ is high, assert GNT to the selected requester combinationally in the same cycle.
  - At the clock edge, capture owner, WR, ADDR, WDATA and BE (BE forced to 4'hF for loads and fetches); go to ACCESS.
  - If no REQ, GNT stays 0.
- Selection:
  - Only one requester: that requester wins.
  - Both requesting, LS_PRIO=1: LS wins.
  - Both requesting, LS_PRIO=0: the side not granted last wins, and the pointer updates on every grant.
- ACCESS (exactly 1 cycle):
  - Drive oRAM_CE=1 plus the registered WR/ADDR/WDATA/BE. All RAM outputs are 0 in every other state.
  - Store: next state RESP.
  - Load or fetch: next state WAIT, counter cleared.
- WAIT (exactly RAM_LAT cycles):
  - Counter increments each cycle.
  - On the last WAIT cycle, register iRAM_DATA; then go to RESP.
- RESP (1 cycle):
  - Pulse the owner's VALID.
  - Owner's DATA output holds the registered word; for a store completion it is 0.
  - Next state IDLE.
- Latency, with GNT in cycle T:
  - ACCESS at T+1.
  - Load/fetch: VALID at T+2+RAM_LAT (T+3 when RAM_LAT=1).
  - Store: VALID at T+2.
- Throughput: a new GNT is possible no earlier than the IDLE cycle following RESP. Back-to-back loads therefore take 3+RAM_LAT cycles each.
- DATA outputs hold their last value until the next RESP for that same owner.
- Requests arriving outside IDLE are ignored (no GNT); the requester must keep REQ asserted.
- Address is passed through unaligned-unchecked; no address wrap or error detection.
- iRST asserted in any state: next cycle is IDLE with all outputs 0, and no VALID is issued for an abandoned transaction. A store already in ACCESS may have been written.
- Simultaneous REQ deassertion and GNT cycle: GNT is combinational on the current REQ, so no grant is given if REQ is low.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP;
  - owner encoding OWN_IF=0, OWN_LS=1;
  - RAM_LAT_MAX=4;
  - BE_FULL=4'hF.
- One sub-module: rr_arb2, a 2-requester picker with LS_PRIO override and a pointer update on grant. Everything else stays in ram_access_arbiter.

Test Plan:
- Reset, then IF load: IF_REQ addr 0x100 at T with RAM returning 0xDEADBEEF.
  - Expect IF_GNT at T.
  - Expect RAM_CE, WR=0, ADDR=0x100 at T+1.
  - Expect IF_VALID and IF_DATA=0xDEADBEEF at T+3.
- LS store: addr 0x204, WDATA 0x11223344, BE 4'b0011.
  - Expect RAM_CE=1, WR=1, BE=0011 at T+1.
  - Expect LS_VALID with RDATA=0 at T+2, and no RAM_CE at T+2.
- Both REQ held with LS_PRIO=0:
  - Grants alternate LS, IF, LS, IF.
  - Each VALID goes to the matching owner only, with the correct data.
- Same as above with LS_PRIO=1: LS is granted every time while held; IF gets nothing until LS_REQ drops.
- RAM_LAT=3 load:
  - VALID at T+5.
  - Data sampled from iRAM_DATA in the third WAIT cycle; a different value in earlier WAIT cycles is not returned.
- iRST pulsed during WAIT of a load:
  - Next cycle: IDLE, oBUSY=0, all outputs 0.
  - No VALID pulse ever appears for that load.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/ram_access_arbiter_pkg.sv
// Shared encodings and constants for the RAM access arbiter.
// Used by the top module and by the requester picker.
package ram_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned RAM_LAT_MAX = 4;
  localparam int unsigned CNT_W       = $clog2(RAM_LAT_MAX) + 1;
  localparam logic [3:0]  BE_FULL     = 4'hF;

endpackage

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-requester picker: round-robin on contention, optional fixed LS priority.
// The pointer flips to the other side after every grant.
module rr_arb2 #(
  parameter int unsigned LS_PRIO = 0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iEn,
  input  logic iIfReq,
  input  logic iLsReq,
  output logic oIfGnt,
  output logic oLsGnt
);

  logic favourLs_q, favourLs_d;
  logic lsWins;

  always_comb begin
    lsWins     = iLsReq && (!iIfReq || (LS_PRIO != 0) || favourLs_q);
    oLsGnt     = iEn && lsWins;
    oIfGnt     = iEn && iIfReq && !lsWins;
    favourLs_d = favourLs_q;
    if (oIfGnt) begin
      favourLs_d = 1'b1;
    end else if (oLsGnt) begin
      favourLs_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      favourLs_q <= 1'b1;
    end else begin
      favourLs_q <= favourLs_d;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Each accepted request runs IDLE -> ACCESS -> (WAIT x RAM_LAT) -> RESP.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned LS_PRIO = 0
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIF_REQ,
  input  logic [ADDR_W-1:0] iIF_ADDR,
  output logic              oIF_GNT,
  output logic              oIF_VALID,
  output logic [DATA_W-1:0] oIF_DATA,
  input  logic              iLS_REQ,
  input  logic              iLS_WR,
  input  logic [ADDR_W-1:0] iLS_ADDR,
  input  logic [DATA_W-1:0] iLS_WDATA,
  input  logic [3:0]        iLS_BE,
  output logic              oLS_GNT,
  output logic              oLS_VALID,
  output logic [DATA_W-1:0] oLS_RDATA,
  output logic              oRAM_CE,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [DATA_W-1:0] oRAM_WDATA,
  output logic [3:0]        oRAM_BE,
  input  logic [DATA_W-1:0] iRAM_DATA,
  output logic              oBUSY
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  ifData_q, ifData_d;
  logic [DATA_W-1:0]  lsData_q, lsData_d;
  logic               ifGnt, lsGnt;

  // Grants are suppressed during reset so no request is acknowledged and then lost.
  rr_arb2 #(
    .LS_PRIO (LS_PRIO)
  ) uArb (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iEn    ((state_q == ST_IDLE) && !iRST),
    .iIfReq (iIF_REQ),
    .iLsReq (iLS_REQ),
    .oIfGnt (ifGnt),
    .oLsGnt (lsGnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    ifData_d = ifData_q;
    lsData_d = lsData_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lsGnt) begin
          state_d = ST_ACCESS;
          owner_d = OWN_LS;
          wr_d    = iLS_WR;
          addr_d  = iLS_ADDR;
          wdata_d = iLS_WDATA;
          be_d    = iLS_WR ? iLS_BE : BE_FULL;
        end else if (ifGnt) begin
          state_d = ST_ACCESS;
          owner_d = OWN_IF;
          wr_d    = 1'b0;
          addr_d  = iIF_ADDR;
          wdata_d = '0;
          be_d    = BE_FULL;
        end
      end
      ST_ACCESS: begin
        cnt_d = '0;
        if (wr_q) begin
          state_d  = ST_RESP;
          lsData_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RAM_LAT - 1)) begin
          state_d = ST_RESP;
          if (owner_q == OWN_LS) begin
            lsData_d = iRAM_DATA;
          end else begin
            ifData_d = iRAM_DATA;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      ifData_q <= '0;
      lsData_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      ifData_q <= ifData_d;
      lsData_q <= lsData_d;
    end
  end

  always_comb begin
    oIF_GNT    = ifGnt;
    oLS_GNT    = lsGnt;
    oRAM_CE    = (state_q == ST_ACCESS);
    oRAM_WR    = oRAM_CE && wr_q;
    oRAM_ADDR  = oRAM_CE ? addr_q : '0;
    oRAM_WDATA = oRAM_CE ? wdata_q : '0;
    oRAM_BE    = oRAM_CE ? be_q : 4'h0;
    oIF_VALID  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    oLS_VALID  = (state_q == ST_RESP) && (owner_q == OWN_LS);
    oIF_DATA   = ifData_q;
    oLS_RDATA  = lsData_q;
    oBUSY      = (state_q != ST_IDLE);
  end

endmodule
